// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the SRAM RW-port controller.
package sram_ctrl_pkg;

    localparam int DEPTH_DEF  = 32;
    localparam int WIDTH_DEF  = 2;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry response buffer holding read data until the consumer takes it.
module sram_resp_fifo #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [1:0]       count_o,
    output logic             not_empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop so a full or empty buffer can never be corrupted.
    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    // Storage, pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign not_empty_o = (count_q != 2'd0);

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Request/response front end for a single-port masked SRAM: zero-fills the
// array after reset, then issues one port cycle per accepted request and
// returns read data in order through a credit-protected two-entry buffer.
module sram_rw_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wmask,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  resp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [WIDTH-1:0]  mem_wmask,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    localparam ctrl_state_e       RESET_STATE = INIT_CLEAR ? CLEAR : RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              accept;
    logic              credit_ok;
    logic [2:0]        outstanding;

    // Sweep counter walks every address once, then hands over to RUN and stops.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    // State, sweep counter and read-in-flight flag; reset discards pending reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET_STATE;
            clr_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // Credits count reads already owed to the consumer; a same-cycle pop frees one.
    always_comb begin
        pop         = resp_valid && resp_ready;
        outstanding = {2'b00, inflight_q} + {1'b0, fifo_count} - {2'b00, pop};
        credit_ok   = (outstanding < 3'd2);
        init_done   = (state_q == RUN);
        req_ready   = reset_n && init_done && credit_ok;
        accept      = req_valid && req_ready;
        inflight_d  = accept && !req_write;
    end

    // Port drive: fixed zero-fill writes while clearing, request pass-through after.
    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = req_addr;
        mem_wmask = req_wmask;
        mem_wdata = req_wdata;
        if (state_q == CLEAR) begin
            mem_en    = reset_n;
            mem_wmode = 1'b1;
            mem_wmask = '1;
            mem_wdata = '0;
            mem_addr  = clr_cnt_q;
        end else begin
            mem_en    = accept;
            mem_wmode = req_write;
        end
    end

    sram_resp_fifo #(
        .WIDTH (WIDTH)
    ) u_resp_fifo (
        .clk         (clock),
        .rst_n       (reset_n),
        .push_i      (inflight_q),
        .pop_i       (pop),
        .wdata_i     (mem_rdata),
        .rdata_o     (resp_data),
        .count_o     (fifo_count),
        .not_empty_o (resp_valid)
    );

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Self-checking bench: behavioural SRAM macro plus an in-order reference of
// array contents and owed responses, driven by directed and random traffic.
module tb_sram_rw_port_ctrl;

    localparam int DEPTH  = 32;
    localparam int WIDTH  = 2;
    localparam int ADDR_W = 5;

    logic              clock;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wmask;
    logic [WIDTH-1:0]  req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [WIDTH-1:0]  resp_data;
    logic              init_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_wmode;
    logic [WIDTH-1:0]  mem_wmask;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               rdyCycle;
    } resp_t;

    logic [WIDTH-1:0] sramArr [DEPTH];
    logic [WIDTH-1:0] refMem  [DEPTH];
    resp_t            expQ    [$];
    int               cyc;
    int               vectors;
    int               miscompares;

    sram_rw_port_ctrl #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .ADDR_W     (ADDR_W),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .init_done  (init_done),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_wmode  (mem_wmode),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Macro model: masked write at the edge, registered read data the cycle after.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) begin
                sramArr[mem_addr] <= (sramArr[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
            end else begin
                mem_rdata <= sramArr[mem_addr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // One RUN-phase cycle: drive, predict from the reference, compare, advance.
    task automatic applyStimulus(input bit v, input bit w, input int addr,
                                 input logic [WIDTH-1:0] mask, input logic [WIDTH-1:0] data,
                                 input bit rr, output bit accepted);
        bit    expValid;
        bit    popE;
        bit    expReady;
        resp_t entry;
        req_valid  = v;
        req_write  = w;
        req_addr   = ADDR_W'(addr);
        req_wmask  = mask;
        req_wdata  = data;
        resp_ready = rr;
        #1;
        expValid = (expQ.size() > 0) && (expQ[0].rdyCycle <= cyc);
        checkOutput("resp_valid", resp_valid, expValid);
        if (expValid) checkOutput("resp_data", resp_data, expQ[0].data);
        popE     = expValid && rr;
        expReady = (expQ.size() - int'(popE)) < 2;
        checkOutput("req_ready", req_ready, expReady);
        checkOutput("init_done", init_done, 1);
        accepted = v && expReady;
        checkOutput("mem_en", mem_en, accepted);
        if (popE) void'(expQ.pop_front());
        if (accepted) begin
            checkOutput("mem_addr", mem_addr, addr);
            checkOutput("mem_wmode", mem_wmode, w);
            if (w) begin
                checkOutput("mem_wmask", mem_wmask, mask);
                checkOutput("mem_wdata", mem_wdata, data);
                refMem[addr] = (refMem[addr] & ~mask) | (data & mask);
            end else begin
                entry.data     = refMem[addr];
                entry.rdyCycle = cyc + 2;
                expQ.push_back(entry);
            end
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic applyReset();
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        #1;
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_data", resp_data, 0);
        checkOutput("rst_init_done", init_done, 0);
        expQ.delete();
        @(negedge clock);
        @(negedge clock);
    endtask

    // Release reset and follow the zero-fill sweep for n cycles while requests are offered.
    task automatic runSweep(input int n);
        reset_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            req_valid  = 1'b1;
            req_write  = 1'($urandom_range(0, 1));
            req_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
            req_wmask  = WIDTH'($urandom);
            req_wdata  = WIDTH'($urandom);
            resp_ready = 1'($urandom_range(0, 1));
            #1;
            checkOutput("clr_mem_en", mem_en, 1);
            checkOutput("clr_wmode", mem_wmode, 1);
            checkOutput("clr_wmask", mem_wmask, 3);
            checkOutput("clr_wdata", mem_wdata, 0);
            checkOutput("clr_addr", mem_addr, i);
            checkOutput("clr_req_ready", req_ready, 0);
            checkOutput("clr_init_done", init_done, 0);
            checkOutput("clr_resp_valid", resp_valid, 0);
            @(negedge clock);
            cyc++;
        end
        if (n == DEPTH) begin
            for (int a = 0; a < DEPTH; a++) refMem[a] = '0;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        int a;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        reset_n     = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wmask   = '0;
        req_wdata   = '0;
        resp_ready  = 1'b0;
        mem_rdata   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sramArr[i] = WIDTH'($urandom);
            refMem[i]  = sramArr[i];
        end
        #2;
        applyReset();
        runSweep(DEPTH);

        // Full write then read of address 7.
        applyStimulus(1, 1, 7, 2'b11, 2'b10, 1, acc);
        applyStimulus(1, 0, 7, 2'b00, 2'b00, 1, acc);
        repeat (3) applyStimulus(0, 0, 0, 2'b00, 2'b00, 1, acc);

        // Masked write to address 3 over cleared data.
        applyStimulus(1, 1, 3, 2'b01, 2'b11, 1, acc);
        applyStimulus(1, 0, 3, 2'b00, 2'b00, 1, acc);
        repeat (3) applyStimulus(0, 0, 0, 2'b00, 2'b00, 1, acc);

        // Back-to-back reads 0..5 with the consumer stalled for five cycles.
        a = 0;
        for (int c = 0; c < 30 && a < 6; c++) begin
            applyStimulus(1, 0, a, 2'b00, 2'b00, c >= 5, acc);
            if (acc) a++;
        end
        repeat (4) applyStimulus(0, 0, 0, 2'b00, 2'b00, 1, acc);

        // One buffered, one in flight, consumer ready: a third read is still taken.
        applyStimulus(1, 0, 10, 2'b00, 2'b00, 0, acc);
        applyStimulus(1, 0, 11, 2'b00, 2'b00, 0, acc);
        applyStimulus(1, 0, 12, 2'b00, 2'b00, 1, acc);
        repeat (4) applyStimulus(0, 0, 0, 2'b00, 2'b00, 1, acc);

        // Random mixed traffic on a narrow address window to provoke read-after-write.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 7), WIDTH'($urandom), WIDTH'($urandom),
                          $urandom_range(0, 3) != 0, acc);
        end
        for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
            applyStimulus(0, 0, 0, 2'b00, 2'b00, 1, acc);
        end
        checkOutput("drain_empty", expQ.size(), 0);

        // Leave responses pending, then reset while the buffer is full.
        applyStimulus(1, 0, 1, 2'b00, 2'b00, 0, acc);
        applyStimulus(1, 0, 2, 2'b00, 2'b00, 0, acc);
        repeat (2) applyStimulus(0, 0, 0, 2'b00, 2'b00, 0, acc);
        applyReset();

        // Interrupt the sweep at address 15, then confirm it restarts from zero.
        runSweep(15);
        #1;
        checkOutput("sweep_addr15", mem_addr, 15);
        applyReset();
        runSweep(DEPTH);
        applyStimulus(1, 0, 7, 2'b00, 2'b00, 1, acc);
        applyStimulus(1, 0, 3, 2'b00, 2'b00, 1, acc);
        repeat (4) applyStimulus(0, 0, 0, 2'b00, 2'b00, 1, acc);
        checkOutput("final_empty", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
